// File: rtl/sample_stream_tx.sv
// Streams one batch of BATCH host samples to the filter datapath over a data_ready/consume handshake.
// Optional consume watchdog: define SAMPLE_TX_TIMEOUT_EN.
module sample_stream_tx #(
  parameter int DATA_W         = 16,
  parameter int BATCH          = 1000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              data_ready,
  output logic [DATA_W-1:0] sample_out,
  input  logic              consume,
  output logic              busy,
  output logic              batch_done,
  output logic              overrun_err,
  output logic              timeout_err,
  output logic [2:0]        debug_state
);

  localparam int CNT_W = $clog2(BATCH + 1);

  if (BATCH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sample_stream_tx: BATCH and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_OFFER = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [CNT_W-1:0]  push_cnt, sent_cnt;
  logic              push, pop, take, clear, start_ok, wd_fire;

  // Host side: src_valid/src_ready is a standard valid/ready pair (transfer when both are high);
  // the receiver side is level data_ready with a one-cycle consume pulse per taken sample.
  assign busy        = (state != S_IDLE);
  assign data_ready  = (state == S_OFFER);
  assign batch_done  = (state == S_DONE);
  assign debug_state = state;
  assign src_ready   = busy && (fifo_cnt < 2'd2) && (push_cnt < CNT_W'(BATCH));

  assign start_ok = (state == S_IDLE) && start && !abort;
  assign push     = src_valid && src_ready && !abort && !wd_fire;
  assign pop      = (state == S_LOAD) && (fifo_cnt != 2'd0) && !abort;
  assign take     = data_ready && consume && !abort;
  // Counters and FIFO return to empty on abort/timeout, at batch start and once the batch completes.
  assign clear    = abort || wd_fire || start_ok || (state == S_DONE);

  always_comb begin
    state_nxt = state;
    if (abort || wd_fire) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_LOAD;
        S_LOAD:  if (fifo_cnt != 2'd0) state_nxt = S_OFFER;
        S_OFFER: if (consume) state_nxt = (sent_cnt == CNT_W'(BATCH - 1)) ? S_DONE : S_GAP;
        S_GAP:   state_nxt = S_LOAD;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= src_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      push_cnt <= '0;
      sent_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      push_cnt <= '0;
      sent_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= ~wr_ptr;
        push_cnt <= push_cnt + 1'b1;
      end
      if (pop)  rd_ptr   <= ~rd_ptr;
      if (take) sent_cnt <= sent_cnt + 1'b1;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // sample_out is only ever reloaded by a pop, so it keeps its last value between offers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)  sample_out <= '0;
    else if (pop)  sample_out <= fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                             overrun_err <= 1'b0;
    else if (start_ok)                        overrun_err <= 1'b0;
    else if (consume && !data_ready && !abort) overrun_err <= 1'b1;
  end

`ifdef SAMPLE_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_fire     = (state == S_OFFER) && !consume && !abort &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != S_OFFER || consume || wd_fire) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + 1'b1;
      if (start_ok)     timeout_q <= 1'b0;
      else if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
